// File: rtl/median_pkg.sv
// Shared definitions for the 3x3 median window front end.
// Holds the frame-sequencing FSM encodings and the default pixel width.
// No logic; imported by the line buffer and the window generator.
package median_pkg;

    // Default pixel width in bits
    localparam int DEFAULT_DATA_SIZE = 8;

    // Frame sequencing states:
    //   S_IDLE - waiting for a start-of-frame pixel
    //   S_FILL - rows 0 and 1, line buffers priming, no windows
    //   S_RUN  - rows 2 and later, windows produced for col >= 2
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FILL = 2'b01,
        S_RUN  = 2'b10
    } median_state_e;

endpackage : median_pkg

// File: rtl/median_line_buffer.sv
// One row of pixel storage: synchronous write, asynchronous read.
// Latency: read data is combinational from the address; writes land on the next clock edge.
// Backpressure: none, accepts one write per clock when wr_en_i is high.
module median_line_buffer
    import median_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int DEPTH     = 640,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [DATA_SIZE-1:0] wr_dat_i,
    output logic [DATA_SIZE-1:0] rd_dat_o
);

    // Storage is deliberately not reset; consumers gate stale contents themselves.
    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    // Read returns the value stored before any write in this cycle, which gives
    // read-before-write behaviour at a shared address.
    assign rd_dat_o = mem_q[addr_i];

    // Store the new pixel at the addressed column.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_dat_i;
        end
    end

endmodule : median_line_buffer

// File: rtl/median_window_gen.sv
// Raster-to-3x3-window generator: buffers two rows and emits every full interior window.
// Latency: 1 cycle from accepted pixel to registered window on winOut0..8.
// Backpressure: none, sustains one pixel per clock; pixels arriving in IDLE without pixSof are dropped.
module median_window_gen
    import median_pkg::*;
#(
    parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] pixIn,
    input  logic                 pixValid,
    input  logic                 pixSof,
    output logic [DATA_SIZE-1:0] winOut0,
    output logic [DATA_SIZE-1:0] winOut1,
    output logic [DATA_SIZE-1:0] winOut2,
    output logic [DATA_SIZE-1:0] winOut3,
    output logic [DATA_SIZE-1:0] winOut4,
    output logic [DATA_SIZE-1:0] winOut5,
    output logic [DATA_SIZE-1:0] winOut6,
    output logic [DATA_SIZE-1:0] winOut7,
    output logic [DATA_SIZE-1:0] winOut8,
    output logic                 winValid,
    output logic                 frameDone
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

    median_state_e state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic          accept;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          col_last;
    logic          last_pix;

    logic [DATA_SIZE-1:0] lb0_rd_dat;
    logic [DATA_SIZE-1:0] lb1_rd_dat;

    // Index 0 is the oldest column (c-2), index 2 the newest (c).
    logic [DATA_SIZE-1:0] top_q [3];
    logic [DATA_SIZE-1:0] mid_q [3];
    logic [DATA_SIZE-1:0] bot_q [3];

    logic win_vld_q, win_vld_d;
    logic frame_done_q, frame_done_d;

    // A pixel is taken when a frame is in progress, or when it opens a new frame.
    assign accept = pixValid && (pixSof || (state_q != S_IDLE));

    // A start-of-frame pixel is always (0,0), whatever the counters held.
    assign cur_col  = pixSof ? '0 : col_q;
    assign cur_row  = pixSof ? '0 : row_q;
    assign col_last = (cur_col == COL_LAST);
    assign last_pix = col_last && (cur_row == ROW_LAST);

    // Row r-1 store: written with the incoming pixel.
    median_line_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (IMG_WIDTH)
    ) u_lb0 (
        .clk      (clk),
        .wr_en_i  (accept),
        .addr_i   (cur_col),
        .wr_dat_i (pixIn),
        .rd_dat_o (lb0_rd_dat)
    );

    // Row r-2 store: receives what row r-1 held at this column before the update.
    median_line_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (IMG_WIDTH)
    ) u_lb1 (
        .clk      (clk),
        .wr_en_i  (accept),
        .addr_i   (cur_col),
        .wr_dat_i (lb0_rd_dat),
        .rd_dat_o (lb1_rd_dat)
    );

    // Raster position of the next pixel; wraps column then row.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // Frame sequencing and end-of-frame pulse.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (pixSof) begin
                        state_d = S_FILL;
                    end else if ((cur_row == ROW_ONE) && col_last) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (pixSof) begin
                        state_d = S_FILL;
                    end else if (last_pix) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Only pixels with a full in-frame neighbourhood produce a window; the row
    // gate also hides line buffer data left over from an interrupted frame.
    always_comb begin
        win_vld_d = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    end

    // State, counters and output flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_vld_q    <= win_vld_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Window columns shift on each accepted pixel and hold through gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
        end else if (accept) begin
            top_q[0] <= top_q[1];
            top_q[1] <= top_q[2];
            top_q[2] <= lb1_rd_dat;
            mid_q[0] <= mid_q[1];
            mid_q[1] <= mid_q[2];
            mid_q[2] <= lb0_rd_dat;
            bot_q[0] <= bot_q[1];
            bot_q[1] <= bot_q[2];
            bot_q[2] <= pixIn;
        end
    end

    assign winOut0   = top_q[0];
    assign winOut1   = top_q[1];
    assign winOut2   = top_q[2];
    assign winOut3   = mid_q[0];
    assign winOut4   = mid_q[1];
    assign winOut5   = mid_q[2];
    assign winOut6   = bot_q[0];
    assign winOut7   = bot_q[1];
    assign winOut8   = bot_q[2];
    assign winValid  = win_vld_q;
    assign frameDone = frame_done_q;

endmodule : median_window_gen
